// File: rtl/branch_pkg.sv
// Shared types and constants for the branch/jump resolution unit.
package branch_pkg;

  typedef enum logic [3:0] {
    BR_NOP = 4'd0,
    BEQ    = 4'd1,
    BNE    = 4'd2,
    BLT    = 4'd3,
    BGE    = 4'd4,
    BLTU   = 4'd5,
    BGEU   = 4'd6,
    JAL    = 4'd7,
    JALR   = 4'd8
  } br_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

  localparam int INST_BYTES = 4;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: decides taken from operands and opcode.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [3:0]      op,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (br_op_e'(op))
      BEQ:      taken = (rs1_val == rs2_val);
      BNE:      taken = (rs1_val != rs2_val);
      BLT:      taken = ($signed(rs1_val) <  $signed(rs2_val));
      BGE:      taken = ($signed(rs1_val) >= $signed(rs2_val));
      BLTU:     taken = (rs1_val <  rs2_val);
      BGEU:     taken = (rs1_val >= rs2_val);
      JAL, JALR: taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution with same-cycle redirect and counted squash.
// Optional target alignment trap enabled by defining BR_MISALIGN_CHECK_EN.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_kill,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [3:0]      branch_control,
  output logic            pc_update_control,
  output logic [XLEN-1:0] pc_update_val,
  output logic [XLEN-1:0] link_val,
  output logic            link_valid,
  output logic            ignore_curr_inst,
  output logic            misalign_trap
);

  br_state_e       state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            taken;
  logic            is_jalr;
  logic            is_jump;
  logic            misaligned;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .op      (branch_control),
    .taken   (taken)
  );

  assign is_jalr  = (br_op_e'(branch_control) == JALR);
  assign is_jump  = is_jalr || (br_op_e'(branch_control) == JAL);
  assign jalr_sum = rs1_val + imm;
  assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);

`ifdef BR_MISALIGN_CHECK_EN
  assign misaligned = (target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    pc_update_control = 1'b0;
    pc_update_val     = '0;
    link_val          = '0;
    link_valid        = 1'b0;
    ignore_curr_inst  = 1'b0;
    misalign_trap     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid && taken) begin
          if (misaligned) begin
            misalign_trap = 1'b1;
          end else begin
            pc_update_control = 1'b1;
            pc_update_val     = target;
            link_valid        = is_jump;
            link_val          = is_jump ? (pc + XLEN'(INST_BYTES)) : '0;
            cnt_d             = 3'(FLUSH_DEPTH);
            state_d           = FLUSH;
          end
        end
      end
      FLUSH: begin
        ignore_curr_inst = 1'b1;
        cnt_d            = cnt_q - 3'd1;
        // <=1 rather than ==1 so a corrupted zero count can never lock the unit in FLUSH
        if (cnt_q <= 3'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_kill) begin
      pc_update_control = 1'b0;
      pc_update_val     = '0;
      link_val          = '0;
      link_valid        = 1'b0;
      misalign_trap     = 1'b0;
      state_d           = IDLE;
      cnt_d             = 3'd0;
    end

    // Outputs are silenced combinationally while reset is held low
    if (!i_rst) begin
      pc_update_control = 1'b0;
      pc_update_val     = '0;
      link_val          = '0;
      link_valid        = 1'b0;
      ignore_curr_inst  = 1'b0;
      misalign_trap     = 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases then randomized traffic vs a behavioural model.
module tb_branch_resolve;

  localparam int XLEN = 32;
  localparam int FD   = 3;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic            i_kill;
  logic [XLEN-1:0] pc, imm, rs1_val, rs2_val;
  logic [3:0]      branch_control;
  logic            pc_update_control;
  logic [XLEN-1:0] pc_update_val;
  logic [XLEN-1:0] link_val;
  logic            link_valid;
  logic            ignore_curr_inst;
  logic            misalign_trap;

  int compared   = 0;
  int mismatched = 0;
  int squash     = 0;
  int redirects  = 0;

  logic            e_upd, e_lv, e_ign, e_mis;
  logic [XLEN-1:0] e_val, e_link;

  branch_resolve #(.XLEN(XLEN), .FLUSH_DEPTH(FD)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_valid           (i_valid),
    .i_kill            (i_kill),
    .pc                (pc),
    .imm               (imm),
    .rs1_val           (rs1_val),
    .rs2_val           (rs2_val),
    .branch_control    (branch_control),
    .pc_update_control (pc_update_control),
    .pc_update_val     (pc_update_val),
    .link_val          (link_val),
    .link_valid        (link_valid),
    .ignore_curr_inst  (ignore_curr_inst),
    .misalign_trap     (misalign_trap)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what the unit should present this cycle, from the architectural rules.
  task automatic model_eval();
    logic            tk;
    logic            mis;
    logic [XLEN-1:0] tgt;
    e_upd = 0; e_lv = 0; e_ign = 0; e_mis = 0; e_val = 0; e_link = 0;
    tk = 0;
    if (i_rst) begin
      e_ign = (squash > 0);
      if (squash == 0 && i_valid && !i_kill) begin
        case (branch_control)
          4'd1: tk = (rs1_val == rs2_val);
          4'd2: tk = (rs1_val != rs2_val);
          4'd3: tk = ($signed(rs1_val) <  $signed(rs2_val));
          4'd4: tk = ($signed(rs1_val) >= $signed(rs2_val));
          4'd5: tk = (rs1_val <  rs2_val);
          4'd6: tk = (rs1_val >= rs2_val);
          4'd7, 4'd8: tk = 1;
          default: tk = 0;
        endcase
        if (branch_control == 4'd8) tgt = (rs1_val + imm) & 32'hFFFF_FFFE;
        else                        tgt = pc + imm;
`ifdef BR_MISALIGN_CHECK_EN
        mis = (tgt % 4) != 0;
`else
        mis = 0;
`endif
        if (tk && mis) e_mis = 1;
        else if (tk) begin
          e_upd = 1;
          e_val = tgt;
          if (branch_control >= 4'd7) begin
            e_lv   = 1;
            e_link = pc + 4;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic k, input logic [3:0] op,
                       input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    i_rst = rst; i_valid = v; i_kill = k; branch_control = op;
    pc = p; imm = im; rs1_val = a; rs2_val = b;
  endtask

  // One clock cycle: inputs already driven, check mid-cycle, advance model at the edge.
  task automatic cycle(input string name);
    #3;
    model_eval();
    check({name, ".upd"},  XLEN'(pc_update_control), XLEN'(e_upd));
    check({name, ".val"},  pc_update_val,            e_val);
    check({name, ".link"}, link_val,                 e_link);
    check({name, ".lv"},   XLEN'(link_valid),        XLEN'(e_lv));
    check({name, ".ign"},  XLEN'(ignore_curr_inst),  XLEN'(e_ign));
    check({name, ".mis"},  XLEN'(misalign_trap),     XLEN'(e_mis));
    $display("cycle %-10s op=%0d v=%0d k=%0d rst=%0d -> upd=%0d val=%h link=%h lv=%0d ign=%0d mis=%0d",
             name, branch_control, i_valid, i_kill, i_rst, pc_update_control, pc_update_val,
             link_val, link_valid, ignore_curr_inst, misalign_trap);
    @(posedge i_clk);
    if (!i_rst)          squash = 0;
    else if (i_kill)     squash = 0;
    else if (squash > 0) squash--;
    else if (e_upd) begin
      squash = FD;
      redirects++;
    end
    #1;
  endtask

  initial begin
    int r0;
    drive(0, 1, 0, 4'd7, 32'h100, 32'h20, 32'h1, 32'h2);
    cycle("reset0");
    cycle("reset1");
    drive(1, 0, 0, 4'd0, 0, 0, 0, 0);
    cycle("idle");

    drive(1, 1, 0, 4'd3, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1);
    cycle("blt");
    for (int i = 0; i < FD + 1; i++) begin
      drive(1, 0, 0, 4'd0, 0, 0, 0, 0);
      cycle("blt_flush");
    end

    drive(1, 1, 0, 4'd5, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1);
    cycle("bltu");
    drive(1, 0, 0, 4'd0, 0, 0, 0, 0);
    cycle("bltu_aft");

    drive(1, 1, 0, 4'd8, 32'h40, 32'h0, 32'h1003, 32'h0);
    cycle("jalr");
    for (int i = 0; i < FD; i++) begin
      drive(1, 0, 0, 4'd0, 0, 0, 0, 0);
      cycle("jalr_fl");
    end

    r0 = redirects;
    drive(1, 1, 0, 4'd1, 32'h200, 32'h10, 32'h5, 32'h5);
    cycle("beq");
    drive(1, 1, 0, 4'd2, 32'h204, 32'h40, 32'h5, 32'h6);
    cycle("bne_sq");
    drive(1, 0, 0, 4'd0, 0, 0, 0, 0);
    cycle("fl2");
    cycle("fl3");
    cycle("after");
    check("one_redirect", XLEN'(redirects - r0), XLEN'(1));

    drive(1, 1, 1, 4'd7, 32'h300, 32'h100, 0, 0);
    cycle("jal_kill");
    drive(1, 1, 0, 4'd7, 32'h300, 32'h100, 0, 0);
    cycle("jal");
    drive(1, 0, 1, 4'd0, 0, 0, 0, 0);
    cycle("kill_fl");
    drive(1, 0, 0, 4'd0, 0, 0, 0, 0);
    cycle("post_kill");

    drive(1, 1, 0, 4'd7, 32'h500, 32'h8, 0, 0);
    cycle("jal2");
    drive(0, 1, 0, 4'd1, 0, 0, 0, 0);
    cycle("rst_fl");
    drive(1, 1, 0, 4'd4, 32'hFFFF_FFFC, 32'h8, 32'h5, 32'h5);
    cycle("bge_wrap");

    for (int n = 0; n < 400; n++) begin
      logic [XLEN-1:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive(1, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            4'($urandom_range(0, 15)), $urandom, $urandom, a, b);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
